// File: rtl/dco_pkg.sv
// Shared definitions for the DCO frequency-locking controller.
//   - dco_state_e : controller FSM states
//   - *_DEF       : default parameter values for the controller and meter
//   - DCO_W       : width of the DCO code bus
package dco_pkg;

    localparam int DCO_W        = 8;
    localparam int WIN_LOG2_DEF = 10;
    localparam int CNT_W_DEF    = 16;
    localparam int SETTLE_DEF   = 16;
    localparam int TOL_DEF      = 2;
    localparam int LOCK_CNT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAR_SETTLE = 3'd1,
        ST_SAR_MEAS   = 3'd2,
        ST_SAR_EVAL   = 3'd3,
        ST_TRK_SETTLE = 3'd4,
        ST_TRK_MEAS   = 3'd5,
        ST_TRK_EVAL   = 3'd6
    } dco_state_e;

endpackage

// File: rtl/dco_freq_meter.sv
// Windowed edge counter for the divided DCO clock.
//   clk, rst_n : system clock, async active-low reset
//   win_start  : pulse one cycle before the first window cycle
//   win_clear  : abort any running window (no done pulse)
//   dco_div    : asynchronous divided DCO output
//   win_last   : high during the final cycle of a running window
//   done       : one-cycle pulse, the cycle after the window ends
//   count      : edges seen in the last completed window (saturating)
module dco_freq_meter
    import dco_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             win_start,
    input  logic             win_clear,
    input  logic             dco_div,
    output logic             win_last,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    logic [2:0]          sync_r;
    logic                edge_s;
    logic                active_r;
    logic [WIN_LOG2-1:0] win_cnt_r;
    logic [CNT_W-1:0]    acc_r;
    logic [CNT_W-1:0]    acc_next_s;
    logic [CNT_W-1:0]    count_r;
    logic                done_r;

    // Two synchroniser flops followed by one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], dco_div};
        end
    end

    // Rising-edge detect and saturating accumulate
    always_comb begin
        edge_s = sync_r[1] & ~sync_r[2];
        if (edge_s && (acc_r != {CNT_W{1'b1}})) begin
            acc_next_s = acc_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign win_last = active_r && (win_cnt_r == {WIN_LOG2{1'b1}});

    // Window sequencing: 2^WIN_LOG2 active cycles, result latched at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r  <= 1'b0;
            win_cnt_r <= {WIN_LOG2{1'b0}};
            acc_r     <= {CNT_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (win_clear) begin
                active_r <= 1'b0;
            end else if (win_start) begin
                active_r  <= 1'b1;
                win_cnt_r <= {WIN_LOG2{1'b0}};
                acc_r     <= {CNT_W{1'b0}};
            end else if (active_r) begin
                acc_r     <= acc_next_s;
                win_cnt_r <= win_cnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
                if (win_last) begin
                    active_r <= 1'b0;
                    done_r   <= 1'b1;
                    count_r  <= acc_next_s;
                end
            end
        end
    end

    assign done  = done_r;
    assign count = count_r;

endmodule

// File: rtl/dco_fll_ctrl.sv
// Frequency-locking controller for the 8-bit DCO: SAR search to a target
// edge count, then +/-1 tracking with a dead-band and a lock indicator.
//   clk, rst_n   : system clock, async active-low reset
//   start, stop  : begin search (ignored while busy) / abort to idle
//   target_count : desired edges per window, captured on accepted start
//   dco_div      : asynchronous divided DCO output
//   dco_code     : code driven to the DCO
//   busy, locked : status
//   meas_count   : last window count, meas_valid pulses when it updates
module dco_fll_ctrl
    import dco_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SETTLE   = SETTLE_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] target_count,
    input  logic             dco_div,
    output logic [DCO_W-1:0] dco_code,
    output logic             busy,
    output logic             locked,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam int IDX_W = $clog2(DCO_W);

    dco_state_e       state_r, state_next_s;
    logic [SET_W-1:0] settle_cnt_r;
    logic             in_settle_s, settle_done_s;
    logic [DCO_W-1:0] code_r, code_next_s, sar_code_s;
    logic [IDX_W-1:0] bit_idx_r, bit_idx_next_s;
    logic [CNT_W-1:0] target_r, target_next_s;
    logic [LCK_W-1:0] lock_cnt_r, lock_cnt_next_s;
    logic             locked_r, locked_next_s, busy_r;
    logic             win_start_s, win_last_s, meas_done_s;
    logic [CNT_W-1:0] meas_count_s;
    logic [CNT_W:0]   tgt_hi_s;
    logic [CNT_W-1:0] tgt_lo_s;
    logic             over_s, under_s;

    dco_freq_meter #(
        .WIN_LOG2 (WIN_LOG2),
        .CNT_W    (CNT_W)
    ) u_meter (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_start (win_start_s),
        .win_clear (stop),
        .dco_div   (dco_div),
        .win_last  (win_last_s),
        .done      (meas_done_s),
        .count     (meas_count_s)
    );

    assign in_settle_s   = (state_r == ST_SAR_SETTLE) || (state_r == ST_TRK_SETTLE);
    assign settle_done_s = (settle_cnt_r == SET_W'(SETTLE - 1));

    // Tracking dead-band: upper bound widened by one bit, lower bound floored at 0
    assign tgt_hi_s = {1'b0, target_r} + (CNT_W+1)'(TOL);
    assign tgt_lo_s = (target_r >= CNT_W'(TOL)) ? (target_r - CNT_W'(TOL)) : {CNT_W{1'b0}};
    assign over_s   = ({1'b0, meas_count_s} > tgt_hi_s);
    assign under_s  = (meas_count_s < tgt_lo_s);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; stop overrides everything
    always_comb begin
        state_next_s = state_r;
        if (stop) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:       state_next_s = start ? ST_SAR_SETTLE : ST_IDLE;
                ST_SAR_SETTLE: state_next_s = settle_done_s ? ST_SAR_MEAS : ST_SAR_SETTLE;
                ST_SAR_MEAS:   state_next_s = win_last_s ? ST_SAR_EVAL : ST_SAR_MEAS;
                ST_SAR_EVAL:   state_next_s = (bit_idx_r == {IDX_W{1'b0}}) ? ST_TRK_SETTLE : ST_SAR_SETTLE;
                ST_TRK_SETTLE: state_next_s = settle_done_s ? ST_TRK_MEAS : ST_TRK_SETTLE;
                ST_TRK_MEAS:   state_next_s = win_last_s ? ST_TRK_EVAL : ST_TRK_MEAS;
                ST_TRK_EVAL:   state_next_s = ST_TRK_SETTLE;
                default:       state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output/datapath decisions for the current state
    always_comb begin
        win_start_s     = in_settle_s && settle_done_s && !stop;
        code_next_s     = code_r;
        bit_idx_next_s  = bit_idx_r;
        target_next_s   = target_r;
        lock_cnt_next_s = lock_cnt_r;
        locked_next_s   = locked_r;
        sar_code_s      = code_r;
        if (meas_count_s > target_r) begin
            sar_code_s[bit_idx_r] = 1'b0;
        end else begin
            sar_code_s[bit_idx_r] = code_r[bit_idx_r];
        end
        if (bit_idx_r != {IDX_W{1'b0}}) begin
            sar_code_s[bit_idx_r - IDX_W'(1)] = 1'b1;
        end else begin
            sar_code_s[0] = sar_code_s[0];
        end
        if (stop) begin
            lock_cnt_next_s = {LCK_W{1'b0}};
            locked_next_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        target_next_s   = target_count;
                        code_next_s     = 8'h80;
                        bit_idx_next_s  = IDX_W'(DCO_W - 1);
                        lock_cnt_next_s = {LCK_W{1'b0}};
                        locked_next_s   = 1'b0;
                    end else begin
                        locked_next_s   = 1'b0;
                    end
                end
                ST_SAR_EVAL: begin
                    code_next_s = sar_code_s;
                    if (bit_idx_r != {IDX_W{1'b0}}) begin
                        bit_idx_next_s = bit_idx_r - IDX_W'(1);
                    end else begin
                        bit_idx_next_s = bit_idx_r;
                    end
                end
                ST_TRK_EVAL: begin
                    if (over_s || under_s) begin
                        lock_cnt_next_s = {LCK_W{1'b0}};
                        locked_next_s   = 1'b0;
                        if (over_s) begin
                            code_next_s = (code_r == 8'h00) ? code_r : (code_r - 8'd1);
                        end else begin
                            code_next_s = (code_r == 8'hFF) ? code_r : (code_r + 8'd1);
                        end
                    end else begin
                        // In-tolerance count saturates at LOCK_CNT
                        if (lock_cnt_r != LCK_W'(LOCK_CNT)) begin
                            lock_cnt_next_s = lock_cnt_r + LCK_W'(1);
                        end else begin
                            lock_cnt_next_s = lock_cnt_r;
                        end
                        locked_next_s = (lock_cnt_next_s == LCK_W'(LOCK_CNT));
                    end
                end
                default: begin
                    code_next_s = code_r;
                end
            endcase
        end
    end

    // Settle-time counter, restarted whenever a settle period completes or is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {SET_W{1'b0}};
        end else if (in_settle_s && !settle_done_s) begin
            settle_cnt_r <= settle_cnt_r + SET_W'(1);
        end else begin
            settle_cnt_r <= {SET_W{1'b0}};
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r     <= 8'h00;
            bit_idx_r  <= {IDX_W{1'b0}};
            target_r   <= {CNT_W{1'b0}};
            lock_cnt_r <= {LCK_W{1'b0}};
            locked_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            code_r     <= code_next_s;
            bit_idx_r  <= bit_idx_next_s;
            target_r   <= target_next_s;
            lock_cnt_r <= lock_cnt_next_s;
            locked_r   <= locked_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    assign dco_code   = code_r;
    assign busy       = busy_r;
    assign locked     = locked_r;
    assign meas_count = meas_count_s;
    assign meas_valid = meas_done_s;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
module tb_dco_fll_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, dco_div;
    logic [15:0] target_count;
    logic [7:0]  dco_code;
    logic        busy, locked, meas_valid;
    logic [15:0] meas_count;

    logic [7:0]  tgt_small, code_small, cnt_small;
    logic        busy_small, locked_small, valid_small;

    int errors = 0;
    int checks = 0;
    int model_mode = 0;   // 0 off, 1 count=code, 2 count=code+10
    logic f4_mode = 1'b0; // free-running dco_div at clk/4
    logic [7:0] sar_exp [8];
    int pulses;

    always #5 clk = ~clk;

    assign tgt_small = target_count[7:0];

    dco_fll_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .target_count(target_count), .dco_div(dco_div),
        .dco_code(dco_code), .busy(busy), .locked(locked),
        .meas_count(meas_count), .meas_valid(meas_valid)
    );

    dco_fll_ctrl #(.CNT_W(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .target_count(tgt_small), .dco_div(dco_div),
        .dco_code(code_small), .busy(busy_small), .locked(locked_small),
        .meas_count(cnt_small), .meas_valid(valid_small)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DCO model: after each window trigger, emit a burst of edges inside the next window
    initial begin : dco_model
        int n;
        logic busy_q;
        dco_div = 1'b0;
        busy_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (f4_mode) begin
                dco_div = 1'b1;
                @(negedge clk);
                @(negedge clk);
                dco_div = 1'b0;
                @(negedge clk);
            end else if (model_mode != 0 && (meas_valid || (busy && !busy_q))) begin
                busy_q = busy;
                repeat (20) @(negedge clk);
                n = (model_mode == 2) ? int'(dco_code) + 10 : int'(dco_code);
                for (int i = 0; i < n; i++) begin
                    dco_div = 1'b1;
                    @(negedge clk);
                    dco_div = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                end
            end else begin
                busy_q = busy;
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!meas_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!meas_valid) check_val({"timeout_", tag}, 32'(meas_valid), 32'd1);
    endtask

    task automatic do_start(input logic [15:0] t);
        @(negedge clk);
        target_count = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop(input string tag, input logic [7:0] exp_code);
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk); #1;
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_locked"}, 32'(locked), 32'd0);
        check_val({tag, "_code"}, 32'(dco_code), 32'(exp_code));
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic idle_wait(output int np);
        np = 0;
        repeat (1100) begin
            @(posedge clk); #1;
            if (meas_valid) np++;
        end
    endtask

    initial begin
        sar_exp = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h68, 8'h64, 8'h66, 8'h65};
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; target_count = 16'd0;

        // Reset held with dco_div toggling
        f4_mode = 1'b1;
        pulses = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (meas_valid) pulses++;
        end
        check_val("rst_code", 32'(dco_code), 32'h00);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_count", 32'(meas_count), 32'd0);
        check_val("rst_no_valid", 32'(pulses), 32'd0);
        f4_mode = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b1;

        // SAR convergence to 100, with a start during step 2 that must be ignored
        model_mode = 1;
        do_start(16'd100);
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_code", 32'(dco_code), 32'h80);
        for (int s = 0; s < 8; s++) begin
            wait_valid("sar");
            check_val($sformatf("sar_code%0d", s), 32'(dco_code), 32'(sar_exp[s]));
            check_val($sformatf("sar_cnt%0d", s), 32'(meas_count), 32'(sar_exp[s]));
            if (s == 0) do_start(16'd200);
        end
        @(posedge clk); #1;
        check_val("sar_final", 32'(dco_code), 32'd100);
        for (int k = 1; k <= 4; k++) begin
            wait_valid("lock");
            @(posedge clk); #1;
            check_val($sformatf("lock_w%0d", k), 32'(locked), (k == 4) ? 32'd1 : 32'd0);
        end

        // Tracking: DCO shifts up by 10 counts
        model_mode = 2;
        for (int k = 1; k <= 12; k++) begin
            wait_valid("trk");
            if (k == 1) check_val("trk_cnt1", 32'(meas_count), 32'd110);
            @(posedge clk); #1;
            check_val($sformatf("trk_code%0d", k), 32'(dco_code), (k <= 8) ? 32'(100 - k) : 32'd92);
            check_val($sformatf("trk_lock%0d", k), 32'(locked), (k == 12) ? 32'd1 : 32'd0);
        end
        do_stop("stop_trk", 8'd92);
        idle_wait(pulses);

        // Saturation high
        model_mode = 1;
        do_start(16'hFFFF);
        for (int s = 0; s < 10; s++) wait_valid("sat_hi");
        @(posedge clk); #1;
        check_val("sat_hi_code", 32'(dco_code), 32'hFF);
        check_val("sat_hi_lock", 32'(locked), 32'd0);
        do_stop("stop_hi", 8'hFF);
        idle_wait(pulses);

        // Saturation low
        do_start(16'd0);
        for (int s = 0; s < 10; s++) wait_valid("sat_lo");
        @(posedge clk); #1;
        check_val("sat_lo_code", 32'(dco_code), 32'h00);
        do_stop("stop_lo", 8'h00);
        idle_wait(pulses);

        // Abort during SAR step 4
        do_start(16'd100);
        for (int s = 0; s < 3; s++) wait_valid("abort");
        repeat (500) @(posedge clk);
        do_stop("stop_sar4", 8'h70);
        idle_wait(pulses);
        check_val("abort_no_valid", 32'(pulses), 32'd0);
        check_val("abort_code_held", 32'(dco_code), 32'h70);

        // Asynchronous reset mid-measurement
        do_start(16'd100);
        repeat (500) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_code", 32'(dco_code), 32'h00);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_locked", 32'(locked), 32'd0);
        check_val("arst_count", 32'(meas_count), 32'd0);
        check_val("arst_valid", 32'(meas_valid), 32'd0);
        idle_wait(pulses);
        @(negedge clk);
        rst_n = 1'b1;

        // Edge counter at clk/4, plus saturation in the 8-bit counter
        model_mode = 0;
        f4_mode = 1'b1;
        do_start(16'd256);
        wait_valid("f4");
        check_val("f4_count", 32'(meas_count), 32'd256);
        check_val("f4_small_sat", 32'(cnt_small), 32'hFF);
        f4_mode = 1'b0;
        do_stop("stop_f4", 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
